seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Receive side of the 7-segment display interface: samples an external segment bus,
//  qualifies stable patterns, decodes them back to BCD digits, checks the digits
//  advance by one modulo 10, and counts protocol errors.
//  Used as a loopback monitor or to read a neighbouring seconds-counter tile.
// PARAMETERS
//  STABLE_CYCLES  1024  consecutive cycles a synchronized pattern must hold to be accepted (>=2)
//  CNT_W          16    width of digit_count
//  ERR_W          8     width of err_count
// PORTS
//  clk          in   1      single clock
//  reset        in   1      asynchronous, active-high reset
//  enable       in   1      1 = capture active; 0 = idle
//  seg_in       in   7      segment bus {g,f,e,d,c,b,a}, active-high, asynchronous to clk
//  digit_out    out  4      last accepted digit 0..9
//  digit_valid  out  1      1-cycle pulse: new digit accepted
//  locked       out  1      1 = reference digit held (LOCKED state)
//  seq_err      out  1      1-cycle pulse: accepted digit != (previous+1) mod 10
//  bad_pattern  out  1      1-cycle pulse: stable non-blank pattern is not a digit glyph
//  err_count    out  ERR_W  seq_err + bad_pattern events, saturating
//  digit_count  out  CNT_W  accepted digits, wraps
// BEHAVIOUR
//  - Reset (async): all outputs 0, state HUNT, synchronizer and stability counter 0.
//  - seg_in passes a 2-flop synchronizer (s1, s2). stab_cnt clears on any edge where s2
//    changes, otherwise increments, saturating at STABLE_CYCLES.
//  - Qualification fires once per pattern, when stab_cnt reaches STABLE_CYCLES-1.
//    Outputs are registered: if edge 0 is the first edge at which seg_in holds the new
//    value, pulses are high after edge STABLE_CYCLES+1, for one cycle.
//  - Glyph table (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. 00 = blank.
//  - On qualification, by decode result:
//    - blank: no pulse, no state change.
//    - invalid glyph: bad_pattern pulse, err_count+1, state->HUNT, digit_out held.
//    - valid d, state HUNT: digit_out<=d, digit_valid, digit_count+1, ->LOCKED, no sequence check.
//    - valid d, LOCKED, d==digit_out (glitch re-qualify): ignored, no pulse.
//    - valid d, LOCKED, d==(digit_out+1)%10: digit_out<=d, digit_valid, digit_count+1.
//    - valid d, LOCKED, otherwise: same as previous case, plus seq_err pulse and err_count+1.
//      Stays LOCKED.
//  - Wrap: 9->0 is a legal increment.
//  - seq_err and bad_pattern are mutually exclusive. err_count saturates at all-ones.
//    digit_count wraps to 0.
//  - Glitch shorter than STABLE_CYCLES: counter restarts, no event.
//  - enable=0: synchronizer keeps running; stab_cnt held at 0; no pulses; state->HUNT.
//    digit_out, err_count and digit_count are held.
//  - locked==1 exactly when state is LOCKED.
//  - Reset asserted mid-qualification: any pending event is discarded.
// CONFIGURATION
//  SEG7_ALT_GLYPHS_EN defined: also accepts 6=7C (no top bar), 7=27 (with f), 9=67 (no d),
//    decoding to 6, 7 and 9.
//  SEG7_ALT_GLYPHS_EN undefined: 7C, 27 and 67 are invalid glyphs and raise bad_pattern.
// TESTING (STABLE_CYCLES=8 unless noted)
//  1. Reset, enable=1, seg_in=3F held -> digit_valid after edge 9, digit_out=0, locked=1,
//     digit_count=1.
//  2. Drive 06,5B,...,6F,3F, each held 20 cycles -> 10 more digit_valid pulses, including 9->0.
//     seq_err never asserted; err_count=0.
//  3. Locked on 3 (4F), drive 6D (5) held -> digit_out=5, digit_valid and seq_err in same
//     cycle, err_count=1.
//  4. Locked on 1, pulse seg_in=5B for 5 cycles, then back to 06 -> no digit_valid, no error.
//     Blank 00 held 20 cycles -> no pulse.
//  5. Drive 7C held -> macro undefined: bad_pattern, locked=0, err_count+1.
//     Macro defined: digit_valid, digit_out=6.
//  6. ERR_W=2: 5 bad patterns -> err_count sticks at 3.
//     Assert reset mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// -----------------------------------------------------------------------------
// seg7_capture_decoder
//   Receive side of a 7-segment display link. Synchronizes an external segment
//   bus, qualifies patterns that hold steady for STABLE_CYCLES clocks, decodes
//   them back to BCD, checks that digits advance by one modulo 10 and counts
//   protocol errors.
//
// Parameters
//   STABLE_CYCLES  cycles a synchronized pattern must hold to be accepted (>=2)
//   CNT_W          width of digit_count
//   ERR_W          width of err_count
//
// Ports
//   clk          in   single clock
//   reset        in   asynchronous active-high reset
//   enable       in   1 = capture active, 0 = idle (state forced to HUNT)
//   seg_in       in   [6:0] {g,f,e,d,c,b,a}, active-high, asynchronous to clk
//   digit_out    out  [3:0] last accepted digit
//   digit_valid  out  1-cycle pulse, new digit accepted
//   locked       out  1 while a reference digit is held
//   seq_err      out  1-cycle pulse, accepted digit is not previous+1 mod 10
//   bad_pattern  out  1-cycle pulse, stable non-blank pattern is not a glyph
//   err_count    out  [ERR_W-1:0] seq_err + bad_pattern events, saturating
//   digit_count  out  [CNT_W-1:0] accepted digits, wrapping
//
// Configuration
//   SEG7_ALT_GLYPHS_EN  when defined, also accept 7C (6), 27 (7) and 67 (9).
// -----------------------------------------------------------------------------
module seg7_capture_decoder #(
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 16,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [6:0]       seg_in,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   output logic             locked,
   output logic             seq_err,
   output logic             bad_pattern,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] digit_count
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] QUAL_AT = SC_W'(STABLE_CYCLES - 1);
   localparam logic [SC_W-1:0] SAT_AT  = SC_W'(STABLE_CYCLES);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [6:0]        s1_q, s1_d, s2_q, s2_d;
   logic [SC_W-1:0]   stab_q, stab_d;
   logic [3:0]        digit_q, digit_d;
   logic              dv_q, dv_d, seq_q, seq_d, bad_q, bad_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              qual, dec_ok;
   logic [3:0]        dec_digit, next_digit;

   // Glyph decode; blank (00) is handled separately by the caller.
   always_comb begin
      dec_ok    = 1'b1;
      dec_digit = 4'd0;
      case (s2_q)
         7'h3F: dec_digit = 4'd0;
         7'h06: dec_digit = 4'd1;
         7'h5B: dec_digit = 4'd2;
         7'h4F: dec_digit = 4'd3;
         7'h66: dec_digit = 4'd4;
         7'h6D: dec_digit = 4'd5;
         7'h7D: dec_digit = 4'd6;
         7'h07: dec_digit = 4'd7;
         7'h7F: dec_digit = 4'd8;
         7'h6F: dec_digit = 4'd9;
`ifdef SEG7_ALT_GLYPHS_EN
         7'h7C: dec_digit = 4'd6;
         7'h27: dec_digit = 4'd7;
         7'h67: dec_digit = 4'd9;
`endif
         default: dec_ok = 1'b0;
      endcase
   end

   assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

   // s1 != s2 means s2 changes at this edge, so the hold restarts.
   // The count saturates at STABLE_CYCLES so each pattern qualifies only once.
   assign qual = enable && (s1_q == s2_q) && (stab_q == QUAL_AT);

   always_comb begin
      s1_d    = seg_in;
      s2_d    = s1_q;
      state_d = state_q;
      digit_d = digit_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      dv_d    = 1'b0;
      seq_d   = 1'b0;
      bad_d   = 1'b0;

      if (!enable || (s1_q != s2_q)) stab_d = '0;
      else if (stab_q != SAT_AT)     stab_d = stab_q + 1'b1;
      else                           stab_d = stab_q;

      if (!enable) begin
         state_d = HUNT;
      end else if (qual && (s2_q != 7'h00)) begin
         if (!dec_ok) begin
            bad_d   = 1'b1;
            state_d = HUNT;
            if (err_q != '1) err_d = err_q + 1'b1;
         end else if (state_q == HUNT) begin
            digit_d = dec_digit;
            dv_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = LOCKED;
         end else if (dec_digit != digit_q) begin
            // Same digit re-qualified after a glitch is silently ignored.
            digit_d = dec_digit;
            dv_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (dec_digit != next_digit) begin
               seq_d = 1'b1;
               if (err_q != '1) err_d = err_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         s1_q    <= '0;
         s2_q    <= '0;
         stab_q  <= '0;
         digit_q <= '0;
         dv_q    <= 1'b0;
         seq_q   <= 1'b0;
         bad_q   <= 1'b0;
         err_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         stab_q  <= stab_d;
         digit_q <= digit_d;
         dv_q    <= dv_d;
         seq_q   <= seq_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = dv_q;
   assign locked      = (state_q == LOCKED);
   assign seq_err     = seq_q;
   assign bad_pattern = bad_q;
   assign err_count   = err_q;
   assign digit_count = cnt_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_capture_decoder
//   Scoreboard bench: each long hold of a pattern pushes the expected event
//   (from a behavioural model of the receive protocol) and a monitor pops and
//   compares whenever the DUT pulses. STABLE_CYCLES=8, ERR_W=2.
// -----------------------------------------------------------------------------
module tb_seg7_capture_decoder;

   localparam int STAB  = 8;
   localparam int CNT_W = 16;
   localparam int ERR_W = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b1;
   logic [6:0]       seg_in = 7'h00;
   logic [3:0]       digit_out;
   logic             digit_valid, locked, seq_err, bad_pattern;
   logic [ERR_W-1:0] err_count;
   logic [CNT_W-1:0] digit_count;

   seg7_capture_decoder #(.STABLE_CYCLES(STAB), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in),
      .digit_out(digit_out), .digit_valid(digit_valid), .locked(locked),
      .seq_err(seq_err), .bad_pattern(bad_pattern),
      .err_count(err_count), .digit_count(digit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       d;
      logic             sq;
      logic             bad;
      logic [ERR_W-1:0] err;
      logic [CNT_W-1:0] cnt;
      logic             lk;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // reference model state
   logic             m_lk = 1'b0;
   logic [3:0]       m_d = 4'd0;
   logic [ERR_W-1:0] m_err = '0;
   logic [CNT_W-1:0] m_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic int glyph(input logic [6:0] p);
      case (p)
         7'h3F: return 0;  7'h06: return 1;  7'h5B: return 2;  7'h4F: return 3;
         7'h66: return 4;  7'h6D: return 5;  7'h7D: return 6;  7'h07: return 7;
         7'h7F: return 8;  7'h6F: return 9;
`ifdef SEG7_ALT_GLYPHS_EN
         7'h7C: return 6;  7'h27: return 7;  7'h67: return 9;
`endif
         default: return -1;
      endcase
   endfunction

   task automatic model_apply(input logic [6:0] p);
      int   g;
      exp_t e;
      g = glyph(p);
      if (p == 7'h00) return;
      e.sq = 1'b0; e.bad = 1'b0;
      if (g < 0) begin
         e.bad = 1'b1;
         m_lk  = 1'b0;
         if (m_err != '1) m_err = m_err + 1'b1;
      end else if (!m_lk) begin
         m_d = 4'(g); m_lk = 1'b1; m_cnt = m_cnt + 1'b1;
      end else if (4'(g) == m_d) begin
         return;
      end else begin
         if (g != (int'(m_d) + 1) % 10) begin
            e.sq = 1'b1;
            if (m_err != '1) m_err = m_err + 1'b1;
         end
         m_d = 4'(g); m_cnt = m_cnt + 1'b1;
      end
      e.d = m_d; e.err = m_err; e.cnt = m_cnt; e.lk = m_lk;
      q.push_back(e);
   endtask

   // Called at a negedge; only holds long enough to qualify produce an event.
   task automatic hold(input logic [6:0] p, input int n);
      seg_in = p;
      if (n >= STAB + 2) model_apply(p);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!reset && (digit_valid || seq_err || bad_pattern)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", 32'(digit_valid), 32'(1'b0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("digit_valid", 32'(digit_valid), 32'(!e.bad));
            chk("bad_pattern", 32'(bad_pattern), 32'(e.bad));
            chk("seq_err",     32'(seq_err),     32'(e.sq));
            chk("digit_out",   32'(digit_out),   32'(e.d));
            chk("err_count",   32'(err_count),   32'(e.err));
            chk("digit_count", 32'(digit_count), 32'(e.cnt));
            chk("locked",      32'(locked),      32'(e.lk));
         end
      end
   end

   initial begin
      logic [6:0] seq_pat [10];
      seq_pat = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};

      repeat (3) @(negedge clk);
      chk("rst_digit_out", 32'(digit_out), 0);
      chk("rst_locked",    32'(locked), 0);
      chk("rst_err_count", 32'(err_count), 0);
      chk("rst_digit_cnt", 32'(digit_count), 0);
      chk("rst_pulses",    32'({digit_valid, seq_err, bad_pattern}), 0);
      reset = 1'b0;

      // first digit from HUNT, then a full legal count including 9->0
      hold(7'h3F, 20);
      chk("t1_locked", 32'(locked), 1);
      chk("t1_count",  32'(digit_count), 1);
      foreach (seq_pat[i]) hold(seq_pat[i], 20);
      chk("t2_err_none", 32'(err_count), 0);
      chk("t2_count",    32'(digit_count), 11);

      // sequence error 3 -> 5
      hold(7'h06, 20); hold(7'h5B, 20); hold(7'h4F, 20);
      hold(7'h6D, 20);
      chk("t3_err", 32'(err_count), 1);

      // glitch then return; blank hold; then legal step
      hold(7'h7D, 20);
      hold(7'h5B, 5);
      hold(7'h7D, 20);
      hold(7'h00, 20);
      hold(7'h07, 20);
      chk("t4_digit", 32'(digit_out), 7);

      // alternate 6 glyph
      hold(7'h7C, 20);
`ifdef SEG7_ALT_GLYPHS_EN
      chk("t5_digit", 32'(digit_out), 6);
      chk("t5_locked", 32'(locked), 1);
`else
      chk("t5_locked", 32'(locked), 0);
      chk("t5_digit_held", 32'(digit_out), 7);
`endif

      // enable low forces HUNT; re-enable re-qualifies the held pattern
      hold(7'h66, 20);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("en0_locked", 32'(locked), 0);
      m_lk = 1'b0;
      enable = 1'b1;
      model_apply(7'h66);
      repeat (20) @(negedge clk);
      chk("en1_locked", 32'(locked), 1);

      // err_count saturation at 2'b11
      hold(7'h01, 20); hold(7'h02, 20); hold(7'h40, 20); hold(7'h7E, 20); hold(7'h3E, 20);
      chk("t6_err_sat", 32'(err_count), 3);

      // reset in the middle of a qualifying hold
      hold(7'h06, 20);
      seg_in = 7'h4F;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_digit", 32'(digit_out), 0);
      chk("mid_rst_locked", 32'(locked), 0);
      chk("mid_rst_err",   32'(err_count), 0);
      chk("mid_rst_cnt",   32'(digit_count), 0);
      chk("mid_rst_pulse", 32'({digit_valid, seq_err, bad_pattern}), 0);
      seg_in = 7'h00;
      m_lk = 1'b0; m_d = 4'd0; m_err = '0; m_cnt = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      hold(7'h00, 20);
      hold(7'h66, 20);
      chk("post_rst_cnt", 32'(digit_count), 1);

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
